// File: rtl/tcu_noc_burst_tx.sv
// tcu_noc_burst_tx
//   Burst transmitter on the TCU->NoC path. One accepted message-write request
//   plus req_len_i payload words become one NoC burst packet: a header flit
//   (burst=1, data0=length) followed by req_len_i payload flits, the last of
//   which carries burst=0. All noc_*_o outputs come from one output register
//   that is held stable while noc_stall_i is asserted.
// Ports
//   clk_i, reset_n_i                 clock, async active-low reset
//   src_chipid_i, src_modid_i        own NoC address (static)
//   req_valid_i/req_ready_o          request handshake; req_trg_*, req_mode_i,
//                                    req_addr_i, req_len_i qualify it
//   data_valid_i/data_ready_o        payload handshake; data_i = {data1,data0},
//                                    data_bsel_i = payload byte select
//   noc_wrreq_o, noc_burst_o, noc_*  flit output register
//   noc_stall_i                      flit taken when noc_wrreq_o && !noc_stall_i
//   busy_o                           packet in progress
//   done_o                           1-cycle pulse after the last flit is taken
//   err_o                            1-cycle pulse after an illegal req_len_i
module tcu_noc_burst_tx #(
  parameter int NOC_BSEL_SIZE        = 8,
  parameter int NOC_CHIPID_SIZE      = 4,
  parameter int NOC_MODID_SIZE       = 4,
  parameter int NOC_MODE_SIZE        = 2,
  parameter int NOC_ADDR_SIZE        = 16,
  parameter int NOC_DATA_SIZE        = 16,
  parameter int MAX_BURST_LENGTH_MSG = 4,
  parameter int LEN_SIZE             = $clog2(MAX_BURST_LENGTH_MSG) + 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [NOC_CHIPID_SIZE-1:0] src_chipid_i,
  input  logic [NOC_MODID_SIZE-1:0]  src_modid_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [NOC_CHIPID_SIZE-1:0] req_trg_chipid_i,
  input  logic [NOC_MODID_SIZE-1:0]  req_trg_modid_i,
  input  logic [NOC_MODE_SIZE-1:0]   req_mode_i,
  input  logic [NOC_ADDR_SIZE-1:0]   req_addr_i,
  input  logic [LEN_SIZE-1:0]        req_len_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  input  logic [2*NOC_DATA_SIZE-1:0] data_i,
  input  logic [NOC_BSEL_SIZE-1:0]   data_bsel_i,
  output logic                       noc_wrreq_o,
  output logic                       noc_burst_o,
  output logic [NOC_BSEL_SIZE-1:0]   noc_bsel_o,
  output logic [NOC_CHIPID_SIZE-1:0] noc_src_chipid_o,
  output logic [NOC_MODID_SIZE-1:0]  noc_src_modid_o,
  output logic [NOC_CHIPID_SIZE-1:0] noc_trg_chipid_o,
  output logic [NOC_MODID_SIZE-1:0]  noc_trg_modid_o,
  output logic [NOC_MODE_SIZE-1:0]   noc_mode_o,
  output logic [NOC_ADDR_SIZE-1:0]   noc_addr_o,
  output logic [NOC_DATA_SIZE-1:0]   noc_data0_o,
  output logic [NOC_DATA_SIZE-1:0]   noc_data1_o,
  input  logic                       noc_stall_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_LAST
  } state_t;

  localparam logic [LEN_SIZE-1:0] LEN_MAX = LEN_SIZE'(MAX_BURST_LENGTH_MSG);
  localparam logic [LEN_SIZE-1:0] LEN_ONE = LEN_SIZE'(1);

  state_t              state, state_nxt;
  logic [LEN_SIZE-1:0] rem;
  logic                load_ok;
  logic                len_ok;
  logic                load_hdr;
  logic                load_pay;
  logic                drop;
  logic                set_done;
  logic                set_err;

  // Output register may take a new flit when empty or when its flit leaves.
  assign load_ok = !noc_wrreq_o || !noc_stall_i;
  assign len_ok  = (req_len_i != '0) && (req_len_i <= LEN_MAX);
  assign busy_o  = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    load_hdr     = 1'b0;
    load_pay     = 1'b0;
    drop         = 1'b0;
    set_done     = 1'b0;
    set_err      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (len_ok) begin
            load_hdr  = 1'b1;
            state_nxt = ST_DATA;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      ST_DATA: begin
        data_ready_o = load_ok;
        if (load_ok) begin
          if (data_valid_i) begin
            load_pay = 1'b1;
            if (rem == LEN_ONE) begin
              state_nxt = ST_LAST;
            end
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_LAST: begin
        // The last flit is always valid here; the cycle it leaves, the next
        // request may already load its header so packets run back to back.
        if (!noc_stall_i) begin
          set_done    = 1'b1;
          req_ready_o = 1'b1;
          state_nxt   = ST_IDLE;
          if (req_valid_i) begin
            if (len_ok) begin
              load_hdr  = 1'b1;
              state_nxt = ST_DATA;
            end else begin
              set_err = 1'b1;
            end
          end
          if (!load_hdr) begin
            drop = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      noc_wrreq_o      <= 1'b0;
      noc_burst_o      <= 1'b0;
      noc_bsel_o       <= '0;
      noc_src_chipid_o <= '0;
      noc_src_modid_o  <= '0;
      noc_trg_chipid_o <= '0;
      noc_trg_modid_o  <= '0;
      noc_mode_o       <= '0;
      noc_addr_o       <= '0;
      noc_data0_o      <= '0;
      noc_data1_o      <= '0;
      rem              <= '0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
    end else begin
      done_o <= set_done;
      err_o  <= set_err;
      if (load_hdr) begin
        noc_wrreq_o      <= 1'b1;
        noc_burst_o      <= 1'b1;
        noc_bsel_o       <= '1;
        noc_src_chipid_o <= src_chipid_i;
        noc_src_modid_o  <= src_modid_i;
        noc_trg_chipid_o <= req_trg_chipid_i;
        noc_trg_modid_o  <= req_trg_modid_i;
        noc_mode_o       <= req_mode_i;
        noc_addr_o       <= req_addr_i;
        noc_data0_o      <= NOC_DATA_SIZE'(req_len_i);
        noc_data1_o      <= '0;
        rem              <= req_len_i;
      end else if (load_pay) begin
        // Address, mode and ids stay as loaded by the header.
        noc_wrreq_o <= 1'b1;
        noc_burst_o <= (rem != LEN_ONE);
        noc_bsel_o  <= data_bsel_i;
        noc_data0_o <= data_i[NOC_DATA_SIZE-1:0];
        noc_data1_o <= data_i[2*NOC_DATA_SIZE-1:NOC_DATA_SIZE];
        rem         <= (rem != '0) ? rem - LEN_ONE : rem;
      end else if (drop) begin
        noc_wrreq_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tcu_noc_burst_tx.sv
// tb_tcu_noc_burst_tx
//   Directed bench for tcu_noc_burst_tx: a per-cycle vector table for the
//   basic packet, illegal lengths and back-to-back packets, then hand-written
//   sequences for header stall, randomised stall/gaps at maximum length and
//   asynchronous reset mid-packet.
module tb_tcu_noc_burst_tx;

  localparam int MAXB = 4;
  localparam int FW   = 76;

  localparam logic [3:0]  SRC_CHIP = 4'h3;
  localparam logic [3:0]  SRC_MOD  = 4'h5;
  localparam logic [3:0]  TC1 = 4'hA;
  localparam logic [3:0]  TM1 = 4'hC;
  localparam logic [1:0]  MD1 = 2'h1;
  localparam logic [15:0] AD1 = 16'h1234;
  localparam logic [3:0]  TC2 = 4'h6;
  localparam logic [3:0]  TM2 = 4'h9;
  localparam logic [1:0]  MD2 = 2'h2;
  localparam logic [15:0] AD2 = 16'hBEE0;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [3:0]  req_trg_chipid_i = TC1;
  logic [3:0]  req_trg_modid_i = TM1;
  logic [1:0]  req_mode_i = MD1;
  logic [15:0] req_addr_i = AD1;
  logic [2:0]  req_len_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [31:0] data_i = '0;
  logic [7:0]  data_bsel_i = '0;
  logic        noc_wrreq_o, noc_burst_o;
  logic [7:0]  noc_bsel_o;
  logic [3:0]  noc_src_chipid_o, noc_src_modid_o, noc_trg_chipid_o, noc_trg_modid_o;
  logic [1:0]  noc_mode_o;
  logic [15:0] noc_addr_o, noc_data0_o, noc_data1_o;
  logic        noc_stall_i = 1'b0;
  logic        busy_o, done_o, err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  tcu_noc_burst_tx #(
    .NOC_BSEL_SIZE(8), .NOC_CHIPID_SIZE(4), .NOC_MODID_SIZE(4), .NOC_MODE_SIZE(2),
    .NOC_ADDR_SIZE(16), .NOC_DATA_SIZE(16), .MAX_BURST_LENGTH_MSG(MAXB)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .src_chipid_i(SRC_CHIP), .src_modid_i(SRC_MOD),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_trg_chipid_i(req_trg_chipid_i), .req_trg_modid_i(req_trg_modid_i),
    .req_mode_i(req_mode_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .data_i(data_i), .data_bsel_i(data_bsel_i),
    .noc_wrreq_o(noc_wrreq_o), .noc_burst_o(noc_burst_o), .noc_bsel_o(noc_bsel_o),
    .noc_src_chipid_o(noc_src_chipid_o), .noc_src_modid_o(noc_src_modid_o),
    .noc_trg_chipid_o(noc_trg_chipid_o), .noc_trg_modid_o(noc_trg_modid_o),
    .noc_mode_o(noc_mode_o), .noc_addr_o(noc_addr_o),
    .noc_data0_o(noc_data0_o), .noc_data1_o(noc_data1_o),
    .noc_stall_i(noc_stall_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  logic [FW-1:0] act_flit;
  assign act_flit = {noc_wrreq_o, noc_burst_o, noc_bsel_o, noc_src_chipid_o, noc_src_modid_o,
                     noc_trg_chipid_o, noc_trg_modid_o, noc_mode_o, noc_addr_o,
                     noc_data1_o, noc_data0_o};

  function automatic logic [FW-1:0] mk_flit(input logic burst, input logic [7:0] bsel,
                                            input logic [3:0] tc, input logic [3:0] tm,
                                            input logic [1:0] md, input logic [15:0] ad,
                                            input logic [15:0] d1, input logic [15:0] d0);
    return {1'b1, burst, bsel, SRC_CHIP, SRC_MOD, tc, tm, md, ad, d1, d0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rv;
    logic [2:0]  len;
    logic        dv;
    logic [31:0] d;
    logic        e_wr;
    logic        e_burst;
    logic [15:0] e_d0;
    logic        e_rrdy;
    logic        e_drdy;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  function automatic vec_t v(input logic rv, input logic [2:0] len, input logic dv,
                             input logic [31:0] d, input logic e_wr, input logic e_burst,
                             input logic [15:0] e_d0, input logic e_rrdy, input logic e_drdy,
                             input logic e_busy, input logic e_done, input logic e_err);
    vec_t r;
    r.rv = rv; r.len = len; r.dv = dv; r.d = d;
    r.e_wr = e_wr; r.e_burst = e_burst; r.e_d0 = e_d0; r.e_rrdy = e_rrdy;
    r.e_drdy = e_drdy; r.e_busy = e_busy; r.e_done = e_done; r.e_err = e_err;
    return r;
  endfunction

  vec_t vecs[16];

  initial begin
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] hdr;
    int taken;
    int acc;
    int cyc;

    // len=3 continuous; len=0 and len=MAX+1 errors; back-to-back len=2 packets
    vecs[0]  = v(1, 3, 0, 32'h0,         0, 0, 16'h0,    1, 0, 0, 0, 0);
    vecs[1]  = v(0, 0, 1, 32'hB001_A001, 1, 1, 16'h0003, 0, 1, 1, 0, 0);
    vecs[2]  = v(0, 0, 1, 32'hB002_A002, 1, 1, 16'hA001, 0, 1, 1, 0, 0);
    vecs[3]  = v(0, 0, 1, 32'hB003_A003, 1, 1, 16'hA002, 0, 1, 1, 0, 0);
    vecs[4]  = v(0, 0, 0, 32'h0,         1, 0, 16'hA003, 1, 0, 1, 0, 0);
    vecs[5]  = v(1, 0, 0, 32'h0,         0, 0, 16'h0,    1, 0, 0, 1, 0);
    vecs[6]  = v(1, 5, 0, 32'h0,         0, 0, 16'h0,    1, 0, 0, 0, 1);
    vecs[7]  = v(0, 0, 0, 32'h0,         0, 0, 16'h0,    1, 0, 0, 0, 1);
    vecs[8]  = v(1, 2, 0, 32'h0,         0, 0, 16'h0,    1, 0, 0, 0, 0);
    vecs[9]  = v(1, 2, 1, 32'hB011_A011, 1, 1, 16'h0002, 0, 1, 1, 0, 0);
    vecs[10] = v(1, 2, 1, 32'hB012_A012, 1, 1, 16'hA011, 0, 1, 1, 0, 0);
    vecs[11] = v(1, 2, 1, 32'hB0FF_A0FF, 1, 0, 16'hA012, 1, 0, 1, 0, 0);
    vecs[12] = v(0, 0, 1, 32'hB021_A021, 1, 1, 16'h0002, 0, 1, 1, 1, 0);
    vecs[13] = v(0, 0, 1, 32'hB022_A022, 1, 1, 16'hA021, 0, 1, 1, 0, 0);
    vecs[14] = v(0, 0, 0, 32'h0,         1, 0, 16'hA022, 1, 0, 1, 0, 0);
    vecs[15] = v(0, 0, 0, 32'h0,         0, 0, 16'h0,    1, 0, 0, 1, 0);

    // Reset state
    @(negedge clk_i); #1;
    check("reset_flit", 128'(act_flit), 128'(0));
    check("reset_ctrl", 128'({req_ready_o, data_ready_o, busy_o, done_o, err_o}), 128'(5'b10000));
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      req_valid_i  = vecs[i].rv;
      req_len_i    = vecs[i].len;
      data_valid_i = vecs[i].dv;
      data_i       = vecs[i].d;
      #1;
      check($sformatf("vec%0d", i),
            128'({noc_wrreq_o, vecs[i].e_wr ? noc_burst_o : 1'b0,
                  vecs[i].e_wr ? noc_data0_o : 16'h0,
                  req_ready_o, data_ready_o, busy_o, done_o, err_o}),
            128'({vecs[i].e_wr, vecs[i].e_burst, vecs[i].e_d0,
                  vecs[i].e_rrdy, vecs[i].e_drdy, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err}));
    end

    // len=1 with the header stalled for 5 cycles
    @(negedge clk_i);
    req_trg_chipid_i = TC2; req_trg_modid_i = TM2; req_mode_i = MD2; req_addr_i = AD2;
    req_valid_i = 1'b1; req_len_i = 3'd1; noc_stall_i = 1'b1;
    hdr = mk_flit(1'b1, 8'hFF, TC2, TM2, MD2, AD2, 16'h0, 16'h0001);
    @(negedge clk_i);
    req_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 32'hCAFE_BEEF; data_bsel_i = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk_i);
      #1;
      check($sformatf("stall_hold%0d", i), 128'({act_flit, data_ready_o}), 128'({hdr, 1'b0}));
    end
    @(negedge clk_i);
    noc_stall_i = 1'b0;
    #1;
    check("stall_release_drdy", 128'({data_ready_o, noc_wrreq_o}), 128'(2'b11));
    @(negedge clk_i);
    data_valid_i = 1'b0;
    #1;
    check("stall_payload",
          128'(act_flit), 128'(mk_flit(1'b0, 8'h0F, TC2, TM2, MD2, AD2, 16'hCAFE, 16'hBEEF)));
    @(negedge clk_i); #1;
    check("stall_done", 128'({done_o, busy_o, noc_wrreq_o}), 128'(3'b100));

    // len=MAX with random stall and data gaps
    @(negedge clk_i);
    req_trg_chipid_i = TC1; req_trg_modid_i = TM1; req_mode_i = MD1; req_addr_i = AD1;
    req_valid_i = 1'b1; req_len_i = 3'(MAXB);
    #1;
    check("max_req_ready", 128'(req_ready_o), 128'(1));
    exp_q.push_back(mk_flit(1'b1, 8'hFF, TC1, TM1, MD1, AD1, 16'h0, 16'(MAXB)));
    taken = 0; acc = 0; cyc = 0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    while (taken < MAXB + 1 && cyc < 200) begin
      if (cyc != 0) @(negedge clk_i);
      cyc++;
      noc_stall_i  = ($urandom_range(0, 2) == 0);
      data_valid_i = ($urandom_range(0, 3) != 0);
      data_i       = {16'hD000 + 16'(acc), 16'h5000 + 16'(acc)};
      data_bsel_i  = 8'(acc + 1);
      #1;
      if (noc_wrreq_o && !noc_stall_i) begin
        if (exp_q.size() == 0) begin
          check($sformatf("max_flit%0d_unexpected", taken), 128'(act_flit), 128'(0));
        end else begin
          check($sformatf("max_flit%0d", taken), 128'(act_flit), 128'(exp_q.pop_front()));
        end
        taken++;
      end
      if (data_valid_i && data_ready_o) begin
        exp_q.push_back(mk_flit(acc + 1 != MAXB, 8'(acc + 1), TC1, TM1, MD1, AD1,
                                16'hD000 + 16'(acc), 16'h5000 + 16'(acc)));
        acc++;
      end
    end
    check("max_flit_count", 128'(taken), 128'(MAXB + 1));
    @(negedge clk_i);
    noc_stall_i = 1'b0; data_valid_i = 1'b0;
    #1;
    check("max_done", 128'({done_o, busy_o, noc_wrreq_o}), 128'(3'b100));

    // Reset mid-payload of a len=4 packet, then a clean len=1 packet
    @(negedge clk_i);
    req_valid_i = 1'b1; req_len_i = 3'd4;
    @(negedge clk_i);
    req_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 32'h1111_2222; data_bsel_i = 8'h03;
    @(negedge clk_i);
    data_i = 32'h3333_4444;
    @(negedge clk_i);
    data_valid_i = 1'b0;
    #1;
    check("rst_pre_flit",
          128'(act_flit), 128'(mk_flit(1'b1, 8'h03, TC1, TM1, MD1, AD1, 16'h3333, 16'h4444)));
    reset_n_i = 1'b0;
    #1;
    check("rst_async",
          128'({act_flit, busy_o, done_o, err_o, data_ready_o}), 128'(0));
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_len_i = 3'd1;
    @(negedge clk_i);
    req_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 32'h5555_6666; data_bsel_i = 8'hF0;
    #1;
    check("rst_new_hdr",
          128'(act_flit), 128'(mk_flit(1'b1, 8'hFF, TC1, TM1, MD1, AD1, 16'h0, 16'h0001)));
    @(negedge clk_i);
    data_valid_i = 1'b0;
    #1;
    check("rst_new_pay",
          128'(act_flit), 128'(mk_flit(1'b0, 8'hF0, TC1, TM1, MD1, AD1, 16'h5555, 16'h6666)));
    @(negedge clk_i); #1;
    check("rst_new_done", 128'({done_o, busy_o, noc_wrreq_o}), 128'(3'b100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
